pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Consumes stage-register fields: source/dest register numbers, wreg, rmem, wmem and jmp.
- Drives hold, flush and bubble enables into the inter-stage pipeline registers, plus EX-stage operand forwarding selects.
- Sequences multi-cycle data-memory waits and the taken-jump flush, and keeps a saturating stall-cycle counter.

Parameters:
- FLUSH_CYCLES, 1, number of cycles flush_if/flush_id stay asserted after a taken jump (1..7).
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before the sticky mem_err is set (1..255).
- R0_ZERO, 1, when 1 register 0 never creates a hazard or forward.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_r2, id_r3  in  4  ID-stage source register numbers.
- id_use_r2, id_use_r3  in  1  ID instruction actually reads that source.
- ex_r2, ex_r3  in  4  EX-stage source register numbers.
- ex_destr  in  4  EX-stage destination register.
- ex_wreg, ex_rmem  in  1  EX-stage writes a register / is a load.
- ex_jmp  in  2  EX jump type: 00 none, 01 unconditional, 10 conditional.
- ex_taken  in  1  EX conditional jump resolved taken.
- mem_destr  in  4  MEM-stage destination register.
- mem_wreg, mem_rmem, mem_wmem  in  1  MEM-stage control bits.
- mem_ready  in  1  data memory completes this cycle.
- wb_destr  in  4  WB-stage destination register.
- wb_wreg  in  1  WB-stage writes a register.
- hold_front  out  1  hold PC and the IF/ID register.
- hold_back  out  1  hold ID/EX and EX/MEM; MEM/WB loads a bubble.
- bubble_ex  out  1  load NOP (all control bits 0) into ID/EX.
- flush_if, flush_id  out  1  clear IF/ID / ID/EX contents to NOP.
- fwd_r2, fwd_r3  out  2  EX operand select: 00 regfile, 01 MEM ALU result, 10 WB value.
- stall_cnt  out  16  saturating count of cycles with hold_front=1.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- rst low, asynchronously: state=RUN, flush and timeout counters 0, stall_cnt=0, mem_err=0.
- While rst is low, every control output is 0 and fwd_r2/fwd_r3=00.
- States: RUN, MEM_WAIT, FLUSH. Control outputs are combinational from state and inputs; state and counters are registered.
- Condition memop = mem_rmem | mem_wmem.
- Condition jump = (ex_jmp==01) | (ex_jmp==10 & ex_taken).
- Condition loaduse = ex_rmem & ex_wreg & ((id_use_r2 & id_r2==ex_destr) | (id_use_r3 & id_r3==ex_destr)). When R0_ZERO=1, ex_destr==0 never matches.
- Priority, highest first: memory wait > jump > load-use.
- Memory wait: memop & !mem_ready in RUN or FLUSH asserts hold_front=1 and hold_back=1 in the same cycle and enters MEM_WAIT next edge. Any pending flush count is frozen.
- MEM_WAIT: hold_front and hold_back stay 1 until the cycle mem_ready=1. That cycle releases both holds and returns to the saved state, RUN or FLUSH with its count.
- Timeout counter: increments each MEM_WAIT cycle. On reaching MEM_TIMEOUT, mem_err=1, stays set until reset, and the FSM is forced to RUN. Zero-wait accesses (mem_ready already 1) never stall.
- Jump (no memory wait): flush_if=1 and flush_id=1 that cycle, and loaduse is ignored. If FLUSH_CYCLES>1, enter FLUSH with count FLUSH_CYCLES-1. FLUSH keeps both flushes asserted and decrements the count, then returns to RUN at 0. A new jump during FLUSH reloads the count.
- Load-use (RUN only): hold_front=1 and bubble_ex=1 for exactly one cycle. The next cycle the load is in MEM and loaduse no longer matches.
- Forwarding, per operand X: fwd_X=01 if mem_wreg & !mem_rmem & mem_destr==ex_X. Else fwd_X=10 if wb_wreg & wb_destr==ex_X. Else 00. MEM has priority over WB. When R0_ZERO=1, ex_X==0 always gives 00.
- stall_cnt: +1 on every edge where hold_front=1, saturating at 16'hFFFF.

Test Plan:
- Load-use: ex_rmem=1, ex_wreg=1, ex_destr=5; id_r2=5, id_use_r2=1 -> one cycle hold_front=1, bubble_ex=1, then 0; stall_cnt=1.
- Double forward: mem_wreg=1, mem_destr=3; wb_wreg=1, wb_destr=3; ex_r2=3 -> fwd_r2=01. Clear mem_wreg -> fwd_r2=10. ex_r3=0 with wb_destr=0 -> fwd_r3=00.
- Memory wait: mem_rmem=1, mem_ready=0 for 4 cycles then 1 -> hold_front=hold_back=1 for 4 cycles, released in the ready cycle; stall_cnt=4.
- Jump priority: ex_jmp=01 with a simultaneous loaduse, FLUSH_CYCLES=2 -> flush_if/flush_id=1 for 2 cycles, bubble_ex stays 0. Same jump while memop & !mem_ready -> holds only; the flush is applied after the wait.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 -> mem_err=1 after 8 wait cycles, FSM in RUN; mem_err survives further traffic.
- Reset mid-operation: assert rst low during MEM_WAIT with stall_cnt=20 -> all outputs 0 immediately, without a clock edge; after release, state RUN and stall_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use bubbles, jump flushes,
// data-memory wait holds with timeout, EX operand forwarding and a stall-cycle counter.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// RUN      | normal flow; load-use bubbles allowed
// MEM_WAIT | data memory busy; front and back held, flush count frozen
// FLUSH    | post-jump flush window; flush_if/flush_id asserted while count runs
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter bit          R0_ZERO      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_r2,
    input  logic [3:0]  id_r3,
    input  logic        id_use_r2,
    input  logic        id_use_r3,
    input  logic [3:0]  ex_r2,
    input  logic [3:0]  ex_r3,
    input  logic [3:0]  ex_destr,
    input  logic        ex_wreg,
    input  logic        ex_rmem,
    input  logic [1:0]  ex_jmp,
    input  logic        ex_taken,
    input  logic [3:0]  mem_destr,
    input  logic        mem_wreg,
    input  logic        mem_rmem,
    input  logic        mem_wmem,
    input  logic        mem_ready,
    input  logic [3:0]  wb_destr,
    input  logic        wb_wreg,
    output logic        hold_front,
    output logic        hold_back,
    output logic        bubble_ex,
    output logic        flush_if,
    output logic        flush_id,
    output logic [1:0]  fwd_r2,
    output logic [1:0]  fwd_r3,
    output logic [15:0] stall_cnt,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [8:0] TMO_LIMIT    = 9'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    state_t      base_state;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        ret_flush_q, ret_flush_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [8:0]  tmo_inc;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mem_err_q, mem_err_d;

    logic memop, jump, loaduse;
    logic ld_hit_r2, ld_hit_r3, ld_dest_ok;
    logic hold_front_c, hold_back_c, bubble_ex_c, flush_c;
    logic [1:0] fwd_r2_c, fwd_r3_c;

    // A load in MEM is not forwarded: its data only exists at WB.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic       m_wreg,
        input logic       m_rmem,
        input logic [3:0] m_destr,
        input logic       w_wreg,
        input logic [3:0] w_destr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (R0_ZERO && src == 4'd0)
            sel = 2'b00;
        else if (m_wreg && !m_rmem && m_destr == src)
            sel = 2'b01;
        else if (w_wreg && w_destr == src)
            sel = 2'b10;
        return sel;
    endfunction

    always_comb begin
        memop      = mem_rmem | mem_wmem;
        jump       = (ex_jmp == 2'b01) | ((ex_jmp == 2'b10) & ex_taken);
        ld_hit_r2  = id_use_r2 && (id_r2 == ex_destr);
        ld_hit_r3  = id_use_r3 && (id_r3 == ex_destr);
        ld_dest_ok = !(R0_ZERO && ex_destr == 4'd0);
        loaduse    = ex_rmem && ex_wreg && ld_dest_ok && (ld_hit_r2 || ld_hit_r3);
        fwd_r2_c   = fwd_sel(ex_r2, mem_wreg, mem_rmem, mem_destr, wb_wreg, wb_destr);
        fwd_r3_c   = fwd_sel(ex_r3, mem_wreg, mem_rmem, mem_destr, wb_wreg, wb_destr);
    end

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        ret_flush_d  = ret_flush_q;
        tmo_d        = tmo_q;
        mem_err_d    = mem_err_q;
        hold_front_c = 1'b0;
        hold_back_c  = 1'b0;
        bubble_ex_c  = 1'b0;
        flush_c      = 1'b0;
        tmo_inc      = {1'b0, tmo_q} + 9'd1;
        base_state   = state_q;
        if (state_q == ST_MEM_WAIT)
            base_state = ret_flush_q ? ST_FLUSH : ST_RUN;

        if (state_q == ST_MEM_WAIT && !mem_ready) begin
            hold_front_c = 1'b1;
            hold_back_c  = 1'b1;
            if (tmo_inc >= TMO_LIMIT) begin
                mem_err_d   = 1'b1;
                state_d     = ST_RUN;
                tmo_d       = 8'd0;
                ret_flush_d = 1'b0;
                flush_cnt_d = 3'd0;
            end else begin
                tmo_d = tmo_inc[7:0];
            end
        end else if (memop && !mem_ready) begin
            hold_front_c = 1'b1;
            hold_back_c  = 1'b1;
            state_d      = ST_MEM_WAIT;
            ret_flush_d  = (state_q == ST_FLUSH);
            tmo_d        = 8'd0;
        end else begin
            // Also the release cycle of a wait: act as the saved state would.
            tmo_d       = 8'd0;
            ret_flush_d = 1'b0;
            if (jump) begin
                flush_c = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_RELOAD;
                end else begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 3'd0;
                end
            end else if (base_state == ST_FLUSH) begin
                flush_c = 1'b1;
                if (flush_cnt_q > 3'd1) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end else begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 3'd0;
                end
            end else begin
                state_d     = ST_RUN;
                flush_cnt_d = 3'd0;
                if (loaduse) begin
                    hold_front_c = 1'b1;
                    bubble_ex_c  = 1'b1;
                end
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (hold_front_c && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            ret_flush_q <= 1'b0;
            tmo_q       <= 8'd0;
            stall_cnt_q <= 16'd0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            ret_flush_q <= ret_flush_d;
            tmo_q       <= tmo_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign hold_front = rst & hold_front_c;
    assign hold_back  = rst & hold_back_c;
    assign bubble_ex  = rst & bubble_ex_c;
    assign flush_if   = rst & flush_c;
    assign flush_id   = rst & flush_c;
    assign fwd_r2     = rst ? fwd_r2_c : 2'b00;
    assign fwd_r3     = rst ? fwd_r3_c : 2'b00;
    assign stall_cnt  = stall_cnt_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_CYCLES=2 and MEM_TIMEOUT=8.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  id_r2, id_r3, ex_r2, ex_r3, ex_destr, mem_destr, wb_destr;
    logic        id_use_r2, id_use_r3, ex_wreg, ex_rmem, ex_taken;
    logic [1:0]  ex_jmp;
    logic        mem_wreg, mem_rmem, mem_wmem, mem_ready, wb_wreg;
    logic        hold_front, hold_back, bubble_ex, flush_if, flush_id, mem_err;
    logic [1:0]  fwd_r2, fwd_r3;
    logic [15:0] stall_cnt;

    int n_tests;
    int n_fail;
    int exp_stall;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(2),
        .MEM_TIMEOUT (8),
        .R0_ZERO     (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .id_r2     (id_r2),
        .id_r3     (id_r3),
        .id_use_r2 (id_use_r2),
        .id_use_r3 (id_use_r3),
        .ex_r2     (ex_r2),
        .ex_r3     (ex_r3),
        .ex_destr  (ex_destr),
        .ex_wreg   (ex_wreg),
        .ex_rmem   (ex_rmem),
        .ex_jmp    (ex_jmp),
        .ex_taken  (ex_taken),
        .mem_destr (mem_destr),
        .mem_wreg  (mem_wreg),
        .mem_rmem  (mem_rmem),
        .mem_wmem  (mem_wmem),
        .mem_ready (mem_ready),
        .wb_destr  (wb_destr),
        .wb_wreg   (wb_wreg),
        .hold_front(hold_front),
        .hold_back (hold_back),
        .bubble_ex (bubble_ex),
        .flush_if  (flush_if),
        .flush_id  (flush_id),
        .fwd_r2    (fwd_r2),
        .fwd_r3    (fwd_r3),
        .stall_cnt (stall_cnt),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_r2 = 4'd0; id_r3 = 4'd0; id_use_r2 = 1'b0; id_use_r3 = 1'b0;
        ex_r2 = 4'd0; ex_r3 = 4'd0; ex_destr = 4'd0;
        ex_wreg = 1'b0; ex_rmem = 1'b0; ex_jmp = 2'b00; ex_taken = 1'b0;
        mem_destr = 4'd0; mem_wreg = 1'b0; mem_rmem = 1'b0; mem_wmem = 1'b0;
        mem_ready = 1'b1; wb_destr = 4'd0; wb_wreg = 1'b0;
    endtask

    task automatic set_loaduse();
        ex_rmem = 1'b1; ex_wreg = 1'b1; ex_destr = 4'd5;
        id_r2 = 4'd5; id_use_r2 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        ex_jmp = 2'b01;
        mem_rmem = 1'b1; mem_ready = 1'b0;
        wb_wreg = 1'b1; wb_destr = 4'd3; ex_r2 = 4'd3;
        #1;
        n_tests++;
        if ({hold_front, hold_back, bubble_ex, flush_if, flush_id} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 00000", {hold_front, hold_back, bubble_ex, flush_if, flush_id});
        end
        n_tests++;
        if (fwd_r2 !== 2'b00) begin
            n_fail++; $display("FAIL reset_fwd: got %b required 00", fwd_r2);
        end
        n_tests++;
        if (stall_cnt !== 16'd0 || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs: stall_cnt %0d mem_err %b required 0 0", stall_cnt, mem_err);
        end
        clear_inputs();
        tick();
        rst = 1'b1;
        exp_stall = 0;
        tick();
    endtask

    task automatic test_load_use();
        set_loaduse();
        #1;
        n_tests++;
        if (hold_front !== 1'b1 || bubble_ex !== 1'b1 || hold_back !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_hit: hf %b bub %b hb %b required 1 1 0", hold_front, bubble_ex, hold_back);
        end
        tick();
        exp_stall += 1;
        clear_inputs();
        mem_rmem = 1'b1; mem_wreg = 1'b1; mem_destr = 4'd5; mem_ready = 1'b1;
        #1;
        n_tests++;
        if (hold_front !== 1'b0 || bubble_ex !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_release: hf %b bub %b required 0 0", hold_front, bubble_ex);
        end
        n_tests++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL loaduse_stall_cnt: got %0d required %0d", stall_cnt, exp_stall);
        end
        clear_inputs();
        ex_rmem = 1'b1; ex_wreg = 1'b1; ex_destr = 4'd6;
        id_r3 = 4'd6; id_use_r3 = 1'b1;
        #1;
        n_tests++;
        if (bubble_ex !== 1'b1) begin
            n_fail++; $display("FAIL loaduse_r3: bub %b required 1", bubble_ex);
        end
        id_use_r3 = 1'b0;
        #1;
        n_tests++;
        if (bubble_ex !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_unused_src: bub %b required 0", bubble_ex);
        end
        ex_destr = 4'd0; id_r2 = 4'd0; id_use_r2 = 1'b1;
        #1;
        n_tests++;
        if (hold_front !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_r0: hf %b required 0", hold_front);
        end
        clear_inputs();
    endtask

    task automatic test_forward();
        mem_wreg = 1'b1; mem_destr = 4'd3; wb_wreg = 1'b1; wb_destr = 4'd3; ex_r2 = 4'd3;
        #1;
        n_tests++;
        if (fwd_r2 !== 2'b01) begin
            n_fail++; $display("FAIL fwd_mem_priority: got %b required 01", fwd_r2);
        end
        mem_rmem = 1'b1;
        #1;
        n_tests++;
        if (fwd_r2 !== 2'b10) begin
            n_fail++; $display("FAIL fwd_mem_load: got %b required 10", fwd_r2);
        end
        mem_rmem = 1'b0; mem_wreg = 1'b0;
        #1;
        n_tests++;
        if (fwd_r2 !== 2'b10) begin
            n_fail++; $display("FAIL fwd_wb: got %b required 10", fwd_r2);
        end
        ex_r3 = 4'd0; wb_destr = 4'd0;
        #1;
        n_tests++;
        if (fwd_r3 !== 2'b00) begin
            n_fail++; $display("FAIL fwd_r0: got %b required 00", fwd_r3);
        end
        ex_r3 = 4'd7; wb_destr = 4'd7; mem_wreg = 1'b1; mem_destr = 4'd7;
        #1;
        n_tests++;
        if (fwd_r3 !== 2'b01 || fwd_r2 !== 2'b00) begin
            n_fail++; $display("FAIL fwd_r3_mem: r3 %b r2 %b required 01 00", fwd_r3, fwd_r2);
        end
        wb_wreg = 1'b0; mem_wreg = 1'b0;
        #1;
        n_tests++;
        if (fwd_r3 !== 2'b00) begin
            n_fail++; $display("FAIL fwd_none: got %b required 00", fwd_r3);
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        mem_rmem = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (hold_front !== 1'b1 || hold_back !== 1'b1) begin
                n_fail++; $display("FAIL memwait_hold cycle %0d: hf %b hb %b required 1 1", i, hold_front, hold_back);
            end
            tick();
            exp_stall += 1;
        end
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (hold_front !== 1'b0 || hold_back !== 1'b0) begin
            n_fail++; $display("FAIL memwait_release: hf %b hb %b required 0 0", hold_front, hold_back);
        end
        tick();
        mem_rmem = 1'b0; mem_wmem = 1'b1;
        #1;
        n_tests++;
        if (hold_front !== 1'b0) begin
            n_fail++; $display("FAIL memwait_zero_wait: hf %b required 0", hold_front);
        end
        tick();
        n_tests++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL memwait_stall_cnt: got %0d required %0d", stall_cnt, exp_stall);
        end
        clear_inputs();
    endtask

    task automatic test_jump();
        set_loaduse();
        ex_jmp = 2'b01;
        #1;
        n_tests++;
        if (flush_if !== 1'b1 || flush_id !== 1'b1 || bubble_ex !== 1'b0 || hold_front !== 1'b0) begin
            n_fail++; $display("FAIL jump_first: fi %b fd %b bub %b hf %b required 1 1 0 0", flush_if, flush_id, bubble_ex, hold_front);
        end
        tick();
        ex_jmp = 2'b00;
        #1;
        n_tests++;
        if (flush_if !== 1'b1 || flush_id !== 1'b1 || bubble_ex !== 1'b0) begin
            n_fail++; $display("FAIL jump_second: fi %b fd %b bub %b required 1 1 0", flush_if, flush_id, bubble_ex);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (flush_if !== 1'b0 || flush_id !== 1'b0) begin
            n_fail++; $display("FAIL jump_end: fi %b fd %b required 0 0", flush_if, flush_id);
        end
        ex_jmp = 2'b10; ex_taken = 1'b0;
        #1;
        n_tests++;
        if (flush_if !== 1'b0) begin
            n_fail++; $display("FAIL jump_not_taken: fi %b required 0", flush_if);
        end
        ex_taken = 1'b1;
        #1;
        n_tests++;
        if (flush_if !== 1'b1) begin
            n_fail++; $display("FAIL jump_taken: fi %b required 1", flush_if);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (flush_id !== 1'b1) begin
            n_fail++; $display("FAIL jump_taken_second: fd %b required 1", flush_id);
        end
        tick();

        // jump presented while the memory is busy: holds only, flush after release
        ex_jmp = 2'b01; mem_rmem = 1'b1; mem_ready = 1'b0;
        #1;
        n_tests++;
        if (hold_front !== 1'b1 || hold_back !== 1'b1 || flush_if !== 1'b0) begin
            n_fail++; $display("FAIL jumpwait_hold: hf %b hb %b fi %b required 1 1 0", hold_front, hold_back, flush_if);
        end
        tick(); exp_stall += 1;
        #1;
        n_tests++;
        if (hold_back !== 1'b1 || flush_id !== 1'b0) begin
            n_fail++; $display("FAIL jumpwait_hold2: hb %b fd %b required 1 0", hold_back, flush_id);
        end
        tick(); exp_stall += 1;
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (hold_front !== 1'b0 || flush_if !== 1'b1) begin
            n_fail++; $display("FAIL jumpwait_release: hf %b fi %b required 0 1", hold_front, flush_if);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (flush_if !== 1'b1) begin
            n_fail++; $display("FAIL jumpwait_flush2: fi %b required 1", flush_if);
        end
        tick();
        #1;
        n_tests++;
        if (flush_if !== 1'b0) begin
            n_fail++; $display("FAIL jumpwait_end: fi %b required 0", flush_if);
        end

        // memory wait arriving inside the flush window freezes the remaining count
        ex_jmp = 2'b01;
        tick();
        ex_jmp = 2'b00; mem_rmem = 1'b1; mem_ready = 1'b0;
        #1;
        n_tests++;
        if (hold_front !== 1'b1 || flush_if !== 1'b0) begin
            n_fail++; $display("FAIL flushwait_hold: hf %b fi %b required 1 0", hold_front, flush_if);
        end
        tick(); exp_stall += 1;
        tick(); exp_stall += 1;
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (hold_front !== 1'b0 || flush_if !== 1'b1) begin
            n_fail++; $display("FAIL flushwait_resume: hf %b fi %b required 0 1", hold_front, flush_if);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (flush_if !== 1'b0) begin
            n_fail++; $display("FAIL flushwait_end: fi %b required 0", flush_if);
        end
        n_tests++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL jump_stall_cnt: got %0d required %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_timeout();
        mem_rmem = 1'b1; mem_ready = 1'b0;
        tick(); exp_stall += 1;
        for (int i = 1; i < 8; i++) begin
            tick(); exp_stall += 1;
        end
        n_tests++;
        if (mem_err !== 1'b0 || hold_back !== 1'b1) begin
            n_fail++; $display("FAIL timeout_early: mem_err %b hb %b required 0 1", mem_err, hold_back);
        end
        tick(); exp_stall += 1;
        n_tests++;
        if (mem_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_set: mem_err %b required 1", mem_err);
        end
        mem_rmem = 1'b0;
        set_loaduse();
        #1;
        n_tests++;
        if (hold_back !== 1'b0 || bubble_ex !== 1'b1) begin
            n_fail++; $display("FAIL timeout_run: hb %b bub %b required 0 1", hold_back, bubble_ex);
        end
        tick(); exp_stall += 1;
        clear_inputs();
        mem_wmem = 1'b1;
        tick();
        tick();
        n_tests++;
        if (mem_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky: mem_err %b required 1", mem_err);
        end
        n_tests++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL timeout_stall_cnt: got %0d required %0d", stall_cnt, exp_stall);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        set_loaduse();
        for (int i = 0; i < 19; i++) tick();
        clear_inputs();
        mem_rmem = 1'b1; mem_ready = 1'b0;
        wb_wreg = 1'b1; wb_destr = 4'd3; ex_r2 = 4'd3;
        tick();
        #1;
        n_tests++;
        if (stall_cnt !== 16'd20 || hold_front !== 1'b1 || fwd_r2 !== 2'b10) begin
            n_fail++; $display("FAIL midreset_pre: stall %0d hf %b fwd %b required 20 1 10", stall_cnt, hold_front, fwd_r2);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({hold_front, hold_back, bubble_ex, flush_if, flush_id} !== 5'b0 || fwd_r2 !== 2'b00) begin
            n_fail++; $display("FAIL midreset_outputs: ctrl %b fwd %b required 00000 00", {hold_front, hold_back, bubble_ex, flush_if, flush_id}, fwd_r2);
        end
        n_tests++;
        if (stall_cnt !== 16'd0 || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_regs: stall %0d mem_err %b required 0 0", stall_cnt, mem_err);
        end
        clear_inputs();
        #2;
        rst = 1'b1;
        tick();
        set_loaduse();
        #1;
        n_tests++;
        if (bubble_ex !== 1'b1 || hold_back !== 1'b0) begin
            n_fail++; $display("FAIL midreset_run: bub %b hb %b required 1 0", bubble_ex, hold_back);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL midreset_stall_cnt: got %0d required 1", stall_cnt);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        exp_stall = 0;
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_jump();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
